// File: rtl/weight_ldr_arbiter.sv
// Round-robin arbiter that serves one weight-memory burst at a time to a set of cache clients.
// Each burst is granted, streamed through a shared data bus with per-client strobes, then closed.
module weight_ldr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned DATA_W  = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        ldr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] ldr_base_addr,
  input  logic [NUM_REQ*CNT_W-1:0]  ldr_count,
  output logic [NUM_REQ-1:0]        ldr_grant,
  output logic [NUM_REQ-1:0]        ldr_valid,
  output logic [DATA_W-1:0]         ldr_data,
  output logic [NUM_REQ-1:0]        ldr_done_sig,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]         mem_rd_data
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StRead,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     sel_q, sel_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  valid_q, valid_d;
  logic [IdxW-1:0]     pick;
  logic                found;
  logic [NUM_REQ-1:0]  sel_oh;
  logic                rd_en;

  // Two passes: clients at or above the pointer first, then wrap to the low indices.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && ldr_req[i] && (i >= int'(32'(rr_ptr_q)))) begin
        found = 1'b1;
        pick  = IdxW'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found && ldr_req[i]) begin
        found = 1'b1;
        pick  = IdxW'(i);
      end
    end
  end

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  assign rd_en = (state_q == StRead);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          sel_d    = pick;
          addr_d   = ldr_base_addr[pick*ADDR_W +: ADDR_W];
          cnt_d    = ldr_count[pick*CNT_W +: CNT_W];
          rr_ptr_d = (pick == IdxW'(NUM_REQ - 1)) ? '0 : pick + IdxW'(1);
          state_d  = StGrant;
        end
      end
      StGrant: state_d = (cnt_q == '0) ? StDone : StRead;
      StRead: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign valid_d = rd_en ? sel_oh : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs are forced low during the reset cycle itself, not only after the edge.
  assign ldr_grant    = (!rst && state_q == StGrant) ? sel_oh : '0;
  assign ldr_done_sig = (!rst && state_q == StDone) ? sel_oh : '0;
  assign ldr_valid    = rst ? '0 : valid_q;
  assign mem_rd_en    = !rst && rd_en;
  assign mem_rd_addr  = (!rst && rd_en) ? addr_q : '0;
  assign ldr_data     = mem_rd_data;

endmodule

// File: tb/tb_weight_ldr_arbiter.sv
// Directed bench for weight_ldr_arbiter: latency, round-robin order, zero-count, address wrap,
// held requests and mid-burst reset, with a one-cycle-latency memory model.
module tb_weight_ldr_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned CNT_W   = 11;
  localparam int unsigned DATA_W  = 128;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        ldr_req;
  logic [NUM_REQ*ADDR_W-1:0] ldr_base_addr;
  logic [NUM_REQ*CNT_W-1:0]  ldr_count;
  logic [NUM_REQ-1:0]        ldr_grant;
  logic [NUM_REQ-1:0]        ldr_valid;
  logic [DATA_W-1:0]         ldr_data;
  logic [NUM_REQ-1:0]        ldr_done_sig;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [DATA_W-1:0]         mem_rd_data;

  int tests;
  int fails;

  weight_ldr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ldr_req      (ldr_req),
    .ldr_base_addr(ldr_base_addr),
    .ldr_count    (ldr_count),
    .ldr_grant    (ldr_grant),
    .ldr_valid    (ldr_valid),
    .ldr_data     (ldr_data),
    .ldr_done_sig (ldr_done_sig),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {32'hC0DE_0000 | {13'h0, a}, 64'hDEAD_BEEF_0123_4567, 13'h0, a};
  endfunction

  // Memory returns the addressed word one cycle after the read enable.
  initial mem_rd_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= word_of(mem_rd_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a request at the current (idle) cycle and checks every output cycle by cycle.
  task automatic run_burst(input logic [NUM_REQ-1:0] mask, input int c,
                           input logic [ADDR_W-1:0] base, input int n, input bit hold);
    logic [NUM_REQ-1:0] oh, exp_grant, exp_valid, exp_done;
    logic               exp_rd;
    logic [ADDR_W-1:0]  exp_addr;
    int                 done_cyc;
    oh       = '0;
    oh[c]    = 1'b1;
    done_cyc = (n == 0) ? 2 : n + 3;
    ldr_req  = mask;
    ldr_base_addr[c*ADDR_W +: ADDR_W] = base;
    ldr_count[c*CNT_W +: CNT_W]       = CNT_W'(n);
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      tick();
      if (cyc == 1) begin
        ldr_base_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        ldr_count[c*CNT_W +: CNT_W]       = CNT_W'($urandom_range(1, 50));
        if (!hold) ldr_req = '0;
      end
      if (hold && cyc == done_cyc) ldr_req = '0;
      exp_grant = (cyc == 1) ? oh : '0;
      exp_rd    = (n > 0) && (cyc >= 2) && (cyc <= n + 1);
      exp_addr  = ADDR_W'(base + ADDR_W'(cyc - 2));
      exp_valid = ((n > 0) && (cyc >= 3) && (cyc <= n + 2)) ? oh : '0;
      exp_done  = (cyc == done_cyc) ? oh : '0;
      tests++;
      if (ldr_grant !== exp_grant) begin
        fails++;
        $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, ldr_grant, exp_grant);
      end
      tests++;
      if (mem_rd_en !== exp_rd) begin
        fails++;
        $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, mem_rd_en, exp_rd);
      end
      if (exp_rd) begin
        tests++;
        if (mem_rd_addr !== exp_addr) begin
          fails++;
          $display("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, mem_rd_addr, exp_addr);
        end
      end
      tests++;
      if (ldr_valid !== exp_valid) begin
        fails++;
        $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, ldr_valid, exp_valid);
      end
      if (exp_valid != '0) begin
        tests++;
        if (ldr_data !== word_of(ADDR_W'(base + ADDR_W'(cyc - 3)))) begin
          fails++;
          $display("FAIL data cyc=%0d got=%h exp=%h", cyc, ldr_data,
                   word_of(ADDR_W'(base + ADDR_W'(cyc - 3))));
        end
      end
      tests++;
      if (ldr_done_sig !== exp_done) begin
        fails++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, ldr_done_sig, exp_done);
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    ldr_req       = '0;
    ldr_base_addr = '0;
    ldr_count     = '0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({ldr_grant, ldr_valid, ldr_done_sig, mem_rd_en, mem_rd_addr} !== '0) begin
        fails++;
        $display("FAIL reset_outputs step=%0d got=%b/%b/%b/%b/%h exp=all zero", k, ldr_grant,
                 ldr_valid, ldr_done_sig, mem_rd_en, mem_rd_addr);
      end
      rst = 1'b0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_grant, exp_valid, exp_done;
    ldr_base_addr = {19'h00040, 19'h00010};
    ldr_count     = {11'd1, 11'd2};
    ldr_req       = 2'b11;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      if (cyc == 12) ldr_req = '0;
      case (cyc)
        1, 12:   exp_grant = 2'b01;
        7:       exp_grant = 2'b10;
        default: exp_grant = 2'b00;
      endcase
      case (cyc)
        3, 4, 14, 15: exp_valid = 2'b01;
        9:            exp_valid = 2'b10;
        default:      exp_valid = 2'b00;
      endcase
      case (cyc)
        5, 16:   exp_done = 2'b01;
        10:      exp_done = 2'b10;
        default: exp_done = 2'b00;
      endcase
      tests++;
      if (ldr_grant !== exp_grant) begin
        fails++;
        $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, ldr_grant, exp_grant);
      end
      tests++;
      if (ldr_valid !== exp_valid) begin
        fails++;
        $display("FAIL rr_valid cyc=%0d got=%b exp=%b", cyc, ldr_valid, exp_valid);
      end
      tests++;
      if (ldr_done_sig !== exp_done) begin
        fails++;
        $display("FAIL rr_done cyc=%0d got=%b exp=%b", cyc, ldr_done_sig, exp_done);
      end
    end
  endtask

  task automatic test_single_burst();
    run_burst(2'b01, 0, 19'h00100, 9, 1'b0);
  endtask

  task automatic test_zero_count();
    run_burst(2'b10, 1, 19'h00abc, 0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    run_burst(2'b01, 0, 19'h7fffe, 4, 1'b0);
  endtask

  task automatic test_held_request();
    run_burst(2'b01, 0, 19'h00020, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (ldr_grant !== 2'b00) begin
        fails++;
        $display("FAIL held_no_regrant step=%0d got=%b exp=00", k, ldr_grant);
      end
    end
    run_burst(2'b01, 0, 19'h00030, 2, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    ldr_base_addr[0 +: ADDR_W] = 19'h00200;
    ldr_count[0 +: CNT_W]      = 11'd9;
    ldr_req = 2'b01;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      if (cyc == 1) ldr_req = '0;
    end
    tests++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 19'h00202) begin
      fails++;
      $display("FAIL third_read got=%b/%h exp=1/00202", mem_rd_en, mem_rd_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ldr_grant, ldr_valid, ldr_done_sig, mem_rd_en} !== '0) begin
      fails++;
      $display("FAIL during_rst got=%b/%b/%b/%b exp=all zero", ldr_grant, ldr_valid,
               ldr_done_sig, mem_rd_en);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tests++;
      if ({ldr_grant, ldr_valid, ldr_done_sig, mem_rd_en, mem_rd_addr} !== '0) begin
        fails++;
        $display("FAIL after_rst step=%0d got=%b/%b/%b/%b/%h exp=all zero", k, ldr_grant,
                 ldr_valid, ldr_done_sig, mem_rd_en, mem_rd_addr);
      end
      tick();
    end
    ldr_base_addr[ADDR_W +: ADDR_W] = 19'h00500;
    ldr_count[CNT_W +: CNT_W]       = 11'd2;
    run_burst(2'b11, 0, 19'h00300, 3, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_zero_count();
    test_addr_wrap();
    test_held_request();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
